// File: rtl/tunnel_scanout.sv
// Display scan-out for the tunnel renderer: VGA timing generator that reads the
// 128x64 depth map from shared BRAM and shows it scaled x4 in a centred window.
module tunnel_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned WIN_X0   = 64,
    parameter int unsigned WIN_Y0   = 112,
    parameter int unsigned WIN_W    = 512,
    parameter int unsigned WIN_H    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        crashed,
    input  logic [1:0]  rdata,
    output logic [12:0] raddr,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [7:0]  rgb,
    output logic        topready
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned OW      = 16;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_HS0  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_HS1  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_WX0  = HW'(WIN_X0);
    localparam logic [HW-1:0] H_WX1  = HW'(WIN_X0 + WIN_W - 1);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_TOP  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_VS0  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_VS1  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_WY0  = VW'(WIN_Y0);
    localparam logic [VW-1:0] V_WY1  = VW'(WIN_Y0 + WIN_H - 1);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          inwin;
    logic          hs_raw;
    logic          vs_raw;
    logic          blank_raw;
    logic [OW-1:0] hoff;
    logic [OW-1:0] voff;
    logic [12:0]   map_addr;
    logic          inwin_s1;
    logic          hs_s1;
    logic          vs_s1;
    logic          blank_s1;
    logic [7:0]    depth_rgb;
    logic [7:0]    pix_rgb;

    // Stage 0: raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    always_comb begin
        inwin     = (hcnt >= H_WX0) && (hcnt <= H_WX1) &&
                    (vcnt >= V_WY0) && (vcnt <= V_WY1);
        hs_raw    = !((hcnt >= H_HS0) && (hcnt <= H_HS1));
        vs_raw    = !((vcnt >= V_VS0) && (vcnt <= V_VS1));
        blank_raw = (hcnt >= H_ACT) || (vcnt >= V_ACT);
        hoff      = OW'(hcnt) - OW'(WIN_X0);
        voff      = OW'(vcnt) - OW'(WIN_Y0);
        map_addr  = {7'(hoff >> 2), 6'(voff >> 2)};
    end

    // Address issue plus stage-1 copies of the raster flags, aligned with rdata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr    <= '0;
            inwin_s1 <= 1'b0;
            hs_s1    <= 1'b1;
            vs_s1    <= 1'b1;
            blank_s1 <= 1'b1;
        end else if (pix_en) begin
            if (inwin) begin
                raddr <= map_addr;
            end
            inwin_s1 <= inwin;
            hs_s1    <= hs_raw;
            vs_s1    <= vs_raw;
            blank_s1 <= blank_raw;
        end
    end

    // Depth-to-colour; crash keeps only the red field
    always_comb begin
        depth_rgb = 8'h00;
        case (rdata)
            2'b01:   depth_rgb = 8'h49;
            2'b10:   depth_rgb = 8'h92;
            2'b11:   depth_rgb = 8'hFF;
            default: depth_rgb = 8'h00;
        endcase
        if (crashed) begin
            depth_rgb = {depth_rgb[7:5], 5'b0_0000};
        end
        pix_rgb = 8'h00;
        if (!blank_s1) begin
            pix_rgb = inwin_s1 ? depth_rgb : 8'h03;
        end
    end

    // Stage 2: registered video outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            blank <= 1'b1;
            rgb   <= 8'h00;
        end else if (pix_en) begin
            hsync <= hs_s1;
            vsync <= vs_s1;
            blank <= blank_s1;
            rgb   <= pix_rgb;
        end
    end

    // Renderer handshake: one clk at the step into vertical blanking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            topready <= 1'b0;
        end else begin
            topready <= pix_en && (hcnt == H_LAST) && (vcnt == V_TOP);
        end
    end

endmodule

// File: tb/tb_tunnel_scanout.sv
// Bench for tunnel_scanout on a shrunken raster so whole frames fit a short run;
// a per-pixel scoreboard runs alongside directed checks.
module tb_tunnel_scanout;

    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 20, VF = 2, VS = 2, VB = 3;
    localparam int WX = 4, WY = 6, WW = 24, WH = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic        inwin;
        logic [12:0] addr;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        crashed;
    logic [1:0]  rdata;
    logic [12:0] raddr;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic [7:0]  rgb;
    logic        topready;

    logic [1:0]  mem [8192];
    int          checks = 0;
    int          errors = 0;
    int          mh, mv, pe_cnt, tr_cnt, tr_at;
    bit          tr_seen, chk_due, pe_run, found;
    logic        crash_s;
    logic [12:0] exp_raddr;
    logic [7:0]  exp_rgb;
    sb_t         q[$];
    sb_t         push_e, pop_e;
    logic [31:0] snap;
    int          tr0;

    tunnel_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .WIN_X0(WX), .WIN_Y0(WY), .WIN_W(WW), .WIN_H(WH)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .crashed(crashed),
        .rdata(rdata), .raddr(raddr), .hsync(hsync), .vsync(vsync),
        .blank(blank), .rgb(rgb), .topready(topready)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM
    always @(posedge clk) rdata <= mem[raddr];

    // Pixel enable: every other clk while running
    always @(posedge clk) begin
        #1;
        pix_en = pe_run ? ~pix_en : 1'b0;
    end

    function automatic logic [7:0] lut(input logic [1:0] d, input logic c);
        logic [7:0] v;
        case (d)
            2'd0:    v = 8'h00;
            2'd1:    v = c ? 8'h40 : 8'h49;
            2'd2:    v = c ? 8'h80 : 8'h92;
            default: v = c ? 8'hE0 : 8'hFF;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference raster: push the expectation for each pixel as it is clocked
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mh = 0; mv = 0; q.delete(); exp_raddr = '0; chk_due = 0; pe_cnt = 0;
        end else if (pix_en) begin
            push_e.inwin = (mh >= WX) && (mh < WX + WW) && (mv >= WY) && (mv < WY + WH);
            push_e.hs    = !((mh >= HA + HF) && (mh < HA + HF + HS));
            push_e.vs    = !((mv >= VA + VF) && (mv < VA + VF + VS));
            push_e.blank = (mh >= HA) || (mv >= VA);
            push_e.addr  = {7'((mh - WX) / 4), 6'((mv - WY) / 4)};
            q.push_back(push_e);
            if (push_e.inwin) exp_raddr = push_e.addr;
            crash_s = crashed;
            chk_due = 1;
            pe_cnt++;
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_due) begin
            chk_due = 0;
            if (q.size() == 2) begin
                pop_e   = q.pop_front();
                exp_rgb = pop_e.blank ? 8'h00 : (!pop_e.inwin ? 8'h03 : lut(mem[pop_e.addr], crash_s));
                chk("sb_pixel", 32'({hsync, vsync, blank, rgb}),
                    32'({pop_e.hs, pop_e.vs, pop_e.blank, exp_rgb}));
            end
            chk("sb_raddr", 32'(raddr), 32'(exp_raddr));
        end
        if (!rst && topready) begin
            tr_cnt++;
            if (!tr_seen) begin
                tr_seen = 1;
                tr_at   = pe_cnt;
            end
            chk("topready_h", 32'(mh), 32'(0));
            chk("topready_v", 32'(mv), 32'(VA));
        end
    end

    task automatic wait_pix(input int n);
        repeat (n) begin
            do @(posedge clk); while (!pix_en);
        end
        @(negedge clk);
    endtask

    task automatic wait_pos(input int h, input int v);
        found = 0;
        for (int i = 0; i < 8000 && !found; i++) begin
            @(negedge clk);
            if (mh == h && mv == v) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $error("FAIL wait_pos timeout observed=none expected=%0d,%0d", h, v);
        end
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; pe_run = 0; crashed = 1'b0;
        tr_cnt = 0; tr_seen = 0; tr_at = 0;
        foreach (mem[i]) mem[i] = 2'($urandom);
        mem[13'h0000] = 2'b11;
        mem[13'h0040] = 2'b01;

        repeat (3) @(negedge clk);
        chk("rst_raddr", 32'(raddr), 32'(0));
        chk("rst_hsync", 32'(hsync), 32'(1));
        chk("rst_vsync", 32'(vsync), 32'(1));
        chk("rst_blank", 32'(blank), 32'(1));
        chk("rst_rgb", 32'(rgb), 32'(0));
        chk("rst_topready", 32'(topready), 32'(0));
        rst = 1'b0;
        pe_run = 1;

        // One full frame: exactly one topready at the right pixel count
        wait_pix(HT * VT);
        chk("frame_topready_cnt", 32'(tr_cnt), 32'(1));
        chk("frame_topready_at", 32'(tr_at), 32'(VA * HT));

        // Window start, address stepping every 4 pixels, crash tint
        wait_pos(WX, WY);
        wait_pix(1);
        chk("raddr_x0", 32'(raddr), 32'h0000);
        wait_pix(1);
        chk("rgb_d11", 32'(rgb), 32'hFF);
        crashed = 1'b1;
        wait_pix(1);
        chk("rgb_d11_crash", 32'(rgb), 32'hE0);
        wait_pix(1);
        chk("raddr_x3", 32'(raddr), 32'h0000);
        wait_pix(1);
        chk("raddr_x4", 32'(raddr), 32'h0040);
        wait_pix(1);
        chk("rgb_d01_crash", 32'(rgb), 32'h40);
        crashed = 1'b0;
        wait_pix(1);
        chk("rgb_d01", 32'(rgb), 32'h49);

        // Border, horizontal blank, vertical sync
        wait_pos(1, 1);
        wait_pix(2);
        chk("border_rgb", 32'(rgb), 32'h03);
        chk("border_blank", 32'(blank), 32'(0));
        wait_pos(HA + 5, 1);
        wait_pix(2);
        chk("hblank_blank", 32'(blank), 32'(1));
        chk("hblank_rgb", 32'(rgb), 32'h00);
        chk("hsync_low", 32'(hsync), 32'(0));
        wait_pos(0, VA + VF);
        wait_pix(2);
        chk("vsync_low", 32'(vsync), 32'(0));

        // Stall just before the blanking step: everything frozen, no topready
        wait_pos(HT - 6, VA - 1);
        pe_run = 0;
        @(posedge clk);
        @(negedge clk);
        snap = 32'({hsync, vsync, blank, rgb, raddr});
        tr0  = tr_cnt;
        repeat (100) begin
            @(negedge clk);
            chk("stall_outputs", 32'({hsync, vsync, blank, rgb, raddr}), snap);
            chk("stall_topready", 32'(topready), 32'(0));
        end
        chk("stall_tr_cnt", 32'(tr_cnt), 32'(tr0));
        pe_run = 1;
        wait_pix(20);
        chk("resume_tr_cnt", 32'(tr_cnt), 32'(tr0 + 1));

        // Mid-frame reset: immediate output reset, scan restarts from (0,0)
        wait_pos(0, 12);
        tr_seen = 0;
        tr_at   = 0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_raddr", 32'(raddr), 32'(0));
        chk("mid_rst_hsync", 32'(hsync), 32'(1));
        chk("mid_rst_vsync", 32'(vsync), 32'(1));
        chk("mid_rst_blank", 32'(blank), 32'(1));
        chk("mid_rst_rgb", 32'(rgb), 32'(0));
        chk("mid_rst_topready", 32'(topready), 32'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8000 && !tr_seen; i++) @(negedge clk);
        chk("post_rst_topready_at", 32'(tr_at), 32'(VA * HT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
